// File: rtl/des_pkg.sv
// DES constants and helpers shared by des_iter_core and des_round.
// Bit numbering throughout: vector bit (W-1) is DES bit 1, so a DES table entry t
// selects vector bit (W_in - t) and output position k (0-based) lands on bit (W_out-1-k).
package des_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each box stored row-major: entry [row*16 + col].
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip_perm(logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned k = 0; k < 48; k++) y[6'(47 - k)] = x[5'(32 - E_T[k])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_T[k])];
    return y;
  endfunction

  // Parity bits (DES 8,16..64) are simply never selected.
  function automatic logic [55:0] pc1_perm(logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
    return y;
  endfunction

  // Row = outer bits b1,b6; column = inner bits b2..b5.
  function automatic logic [31:0] sbox_sub(logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    y = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      six = x[6'(47 - 6 * n) -: 6];
      y[5'(31 - 4 * n) -: 4] = SBOX[3'(n)][{six[5], six[0], six[4:1]}];
    end
    return y;
  endfunction

  // Rotation applied before round idx (0-based). Decrypt walks the schedule backwards:
  // round 0 uses the unrotated key, round j>0 undoes the encrypt shift of round 16-j.
  function automatic logic [1:0] key_shift(logic decrypt, logic [3:0] idx);
    if (!decrypt)        return 2'(SHIFT[idx]);
    else if (idx == '0)  return 2'd0;
    else                 return 2'(SHIFT[4'(5'd16 - 5'(idx))]);
  endfunction

  function automatic logic [27:0] rotl28(logic [27:0] x, logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(logic [27:0] x, logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round with on-the-fly key rotation.
//   l, r         : current Feistel halves
//   c, d         : current key halves (28 bits each)
//   decrypt      : 0 = rotate left (encrypt schedule), 1 = rotate right (decrypt schedule)
//   round_idx    : 0-based round number
//   l_next..d_next : halves after this round; c_next/d_next feed the next round
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic        decrypt,
  input  logic [3:0]  round_idx,
  output logic [31:0] l_next,
  output logic [31:0] r_next,
  output logic [27:0] c_next,
  output logic [27:0] d_next
);

  logic [1:0]  amt;
  logic [47:0] subkey;

  always_comb begin
    amt = key_shift(decrypt, round_idx);
    if (decrypt) begin
      c_next = rotr28(c, amt);
      d_next = rotr28(d, amt);
    end else begin
      c_next = rotl28(c, amt);
      d_next = rotl28(d, amt);
    end
    subkey = pc2_perm({c_next, d_next});
    l_next = r;
    r_next = l ^ p_perm(sbox_sub(e_expand(r) ^ subkey));
  end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine, one 64-bit block in flight, ROUNDS_PER_CYCLE rounds per clock.
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     : input handshake; in_ready high only in IDLE
//   in_decrypt            : 0 = encrypt, 1 = decrypt
//   in_data, in_key       : block and key (bit 63 = DES bit 1, key parity ignored)
//   out_valid/out_ready   : output handshake; out_data held until accepted
//   out_data              : result (bit 63 = DES bit 1)
//   busy                  : high while a block is being processed or waiting to drain
module des_iter_core
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t      state, state_next;
  logic [4:0]  cnt_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        mode_q;
  logic [63:0] out_q;
  logic        last_step;

  logic [31:0] l_ch [ROUNDS_PER_CYCLE + 1];
  logic [31:0] r_ch [ROUNDS_PER_CYCLE + 1];
  logic [27:0] c_ch [ROUNDS_PER_CYCLE + 1];
  logic [27:0] d_ch [ROUNDS_PER_CYCLE + 1];

  assign l_ch[0] = l_q;
  assign r_ch[0] = r_q;
  assign c_ch[0] = c_q;
  assign d_ch[0] = d_q;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    des_round u_round (
      .l         (l_ch[k]),
      .r         (r_ch[k]),
      .c         (c_ch[k]),
      .d         (d_ch[k]),
      .decrypt   (mode_q),
      .round_idx (cnt_q[3:0] + 4'(k)),
      .l_next    (l_ch[k + 1]),
      .r_next    (r_ch[k + 1]),
      .c_next    (c_ch[k + 1]),
      .d_next    (d_ch[k + 1])
    );
  end

  assign last_step = (cnt_q == 5'(16 - ROUNDS_PER_CYCLE));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      mode_q <= 1'b0;
      out_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          {l_q, r_q} <= ip_perm(in_data);
          {c_q, d_q} <= pc1_perm(in_key);
          mode_q     <= in_decrypt;
          cnt_q      <= '0;
        end
        RUN: begin
          l_q   <= l_ch[ROUNDS_PER_CYCLE];
          r_q   <= r_ch[ROUNDS_PER_CYCLE];
          c_q   <= c_ch[ROUNDS_PER_CYCLE];
          d_q   <= d_ch[ROUNDS_PER_CYCLE];
          cnt_q <= cnt_q + 5'(ROUNDS_PER_CYCLE);
          // Final halves are swapped before the inverse permutation.
          if (last_step) out_q <= fp_perm({r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
module tb_des_iter_core;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] CT0  = 64'h8CA64DE9C1B123A7;

  logic        clk, rst;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_data, in_key, out_data;
  logic        in_valid4, in_ready4, out_valid4, busy4;
  logic        in_valid16, in_ready16, out_valid16, busy16;
  logic [63:0] out_data4, out_data16;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] blk_key [100];
  logic [63:0] blk_in  [100];
  logic [63:0] blk_orig[100];
  logic [63:0] blk_out [$];
  logic        drv_timeout;

  des_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy));

  des_iter_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_decrypt(in_decrypt),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid4), .out_ready(1'b1),
    .out_data(out_data4), .busy(busy4));

  des_iter_core #(.ROUNDS_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_decrypt(in_decrypt),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid16), .out_ready(1'b1),
    .out_data(out_data16), .busy(busy16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "simulation time limit");
  end

  // Enters and leaves at #1 after a rising edge with the main DUT idle.
  task automatic run_block(input logic dec, input logic [63:0] key, input logic [63:0] data,
                           output logic [63:0] res, output int lat);
    in_decrypt = dec; in_key = key; in_data = data; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    @(posedge clk); #1;
  endtask

  task automatic run_wide(input logic dec, input logic [63:0] key, input logic [63:0] data,
                          output int lat4, output logic [63:0] res4,
                          output int lat16, output logic [63:0] res16);
    in_decrypt = dec; in_key = key; in_data = data; in_valid4 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_valid16 = 1'b0;
    lat4 = -1; lat16 = -1; res4 = '0; res16 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid4 && lat4 < 0)   begin lat4 = c;  res4 = out_data4;   end
      if (out_valid16 && lat16 < 0) begin lat16 = c; res16 = out_data16; end
    end
  endtask

  task automatic run_stream(input logic dec);
    blk_out.delete();
    drv_timeout = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic acc;
          int   w;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          in_decrypt = dec; in_key = blk_key[i]; in_data = blk_in[i]; in_valid = 1'b1;
          acc = 1'b0; w = 0;
          while (!acc && w < 200) begin
            acc = in_ready;
            @(posedge clk); #1;
            w++;
          end
          in_valid = 1'b0;
          if (!acc) drv_timeout = 1'b1;
        end
      end
      begin
        int cyc = 0;
        while (blk_out.size() < 100 && cyc < 10000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) blk_out.push_back(out_data);
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags got in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if (out_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_out_data got %h required 0000000000000000", out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready4, in_ready16, busy4, busy16} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_wide_flags got %b required 1100", {in_ready4, in_ready16, busy4, busy16});
    end
  endtask

  task automatic test_encrypt();
    logic [63:0] res, res4, res16;
    int lat, lat4, lat16;
    run_block(1'b0, KEY1, PT1, res, lat);
    vectors++;
    if (res !== CT1) begin
      miscompares++;
      $display("FAIL enc_rpc1_data got %h required %h", res, CT1);
    end
    vectors++;
    if (lat !== 16) begin
      miscompares++;
      $display("FAIL enc_rpc1_latency got %0d required 16", lat);
    end
    run_wide(1'b0, KEY1, PT1, lat4, res4, lat16, res16);
    vectors++;
    if (res4 !== CT1 || lat4 !== 4) begin
      miscompares++;
      $display("FAIL enc_rpc4 got %h lat %0d required %h lat 4", res4, lat4, CT1);
    end
    vectors++;
    if (res16 !== CT1 || lat16 !== 1) begin
      miscompares++;
      $display("FAIL enc_rpc16 got %h lat %0d required %h lat 1", res16, lat16, CT1);
    end
  endtask

  task automatic test_decrypt();
    logic [63:0] res, res4, res16;
    int lat, lat4, lat16;
    run_block(1'b1, KEY1, CT1, res, lat);
    vectors++;
    if (res !== PT1 || lat !== 16) begin
      miscompares++;
      $display("FAIL dec_rpc1 got %h lat %0d required %h lat 16", res, lat, PT1);
    end
    run_wide(1'b1, KEY1, CT1, lat4, res4, lat16, res16);
    vectors++;
    if (res4 !== PT1 || lat4 !== 4) begin
      miscompares++;
      $display("FAIL dec_rpc4 got %h lat %0d required %h lat 4", res4, lat4, PT1);
    end
    vectors++;
    if (res16 !== PT1 || lat16 !== 1) begin
      miscompares++;
      $display("FAIL dec_rpc16 got %h lat %0d required %h lat 1", res16, lat16, PT1);
    end
  endtask

  task automatic test_parity();
    logic [63:0] res;
    int lat;
    run_block(1'b0, 64'h0000000000000000, 64'h0, res, lat);
    vectors++;
    if (res !== CT0) begin
      miscompares++;
      $display("FAIL parity_key0 got %h required %h", res, CT0);
    end
    run_block(1'b0, 64'h0101010101010101, 64'h0, res, lat);
    vectors++;
    if (res !== CT0) begin
      miscompares++;
      $display("FAIL parity_key01 got %h required %h", res, CT0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0; in_decrypt = 1'b0; in_key = KEY1; in_data = PT1; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep offering a different block while the first one is in flight.
    in_data = 64'hFFFFFFFFFFFFFFFF; in_key = 64'h0; in_decrypt = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL bp_latency got %0d required 16", n);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== CT1) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got valid/ready/busy=%b%b%b data %h required 101 data %h",
                 i, out_valid, in_ready, busy, out_data, CT1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got valid/ready=%b%b required 01", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] res;
    int lat;
    logic seen;
    in_decrypt = 1'b0; in_key = KEY1; in_data = PT1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_busy got %b required 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 64'h0) begin
      miscompares++;
      $display("FAIL midrun_reset got valid/ready/busy=%b%b%b data %h required 010 data 0",
               out_valid, in_ready, busy, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_pulse got out_valid seen=%b required 0", seen);
    end
    run_block(1'b0, KEY1, PT1, res, lat);
    vectors++;
    if (res !== CT1 || lat !== 16) begin
      miscompares++;
      $display("FAIL midrun_fresh got %h lat %0d required %h lat 16", res, lat, CT1);
    end
  endtask

  task automatic test_back_to_back();
    int same;
    logic seen;
    for (int i = 0; i < 100; i++) begin
      blk_key[i]  = {$urandom, $urandom};
      blk_orig[i] = {$urandom, $urandom};
      blk_in[i]   = blk_orig[i];
    end
    run_stream(1'b0);
    vectors++;
    if (blk_out.size() !== 100 || drv_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_enc_count got %0d blocks timeout=%b required 100 timeout=0",
               blk_out.size(), drv_timeout);
    end
    same = 0;
    for (int i = 0; i < 100; i++) begin
      blk_in[i] = (i < blk_out.size()) ? blk_out[i] : 64'h0;
      if (blk_in[i] === blk_orig[i]) same++;
    end
    vectors++;
    if (same !== 0) begin
      miscompares++;
      $display("FAIL b2b_enc_changed got %0d unchanged blocks required 0", same);
    end
    run_stream(1'b1);
    vectors++;
    if (blk_out.size() !== 100 || drv_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_dec_count got %0d blocks timeout=%b required 100 timeout=0",
               blk_out.size(), drv_timeout);
    end
    for (int i = 0; i < blk_out.size(); i++) begin
      vectors++;
      if (blk_out[i] !== blk_orig[i]) begin
        miscompares++;
        $display("FAIL b2b_roundtrip block %0d got %h required %h", i, blk_out[i], blk_orig[i]);
      end
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_extra_output got out_valid seen=%b required 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; in_valid16 = 1'b0;
    in_decrypt = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_parity();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
